reset_sequencer: RTL and testbench

- Generates the staged reset lines that drive the `rst` pins of async-reset register domains. It is the producer end of those reset inputs.
- Asserts a masked set of domain resets and holds them for a programmable time. Then releases them one domain at a time, in index order, with a fixed gap between releases.
- Runs one full power-on sequence automatically out of `rst`. Also accepts software-requested partial resets over a valid/ready handshake.
- All outputs come straight from flops, so they are glitch-free and safe to use as async resets downstream.

---
 rtl/reset_sequencer_pkg.sv | 19 +
 rtl/reset_seq_down_counter.sv | 36 +++
 rtl/reset_sequencer.sv | 146 ++++++++++++++
 tb/tb_reset_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Index width for n domains; a single domain still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
    endfunction

    localparam int unsigned DEF_NUM_DOMAINS = 4;
    localparam int unsigned DEF_IDX_W       = idx_width(DEF_NUM_DOMAINS);

endpackage

// File: rtl/reset_seq_down_counter.sv
// Load/decrement counter that saturates at zero and flags when it is empty.
module reset_seq_down_counter #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CNT_W'(RST_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Drives per-domain resets: assert a masked set, hold, then release in index order.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS   = DEF_NUM_DOMAINS,
    parameter int unsigned ASSERT_CYCLES = 16,
    parameter int unsigned STAGE_GAP     = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [NUM_DOMAINS-1:0] req_mask,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned IDX_W = idx_width(NUM_DOMAINS);

    state_e                 state_q, state_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic [NUM_DOMAINS-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   req_ready_q, req_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic cnt_load, cnt_dec, cnt_zero_c;
    logic gap_load, gap_dec, gap_zero_c;
    logic [CNT_W-1:0] gap_val;

    reset_seq_down_counter #(
        .CNT_W  (CNT_W),
        .RST_VAL(ASSERT_CYCLES - 1)
    ) u_assert_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(CNT_W'(ASSERT_CYCLES - 1)),
        .dec     (cnt_dec),
        .zero_c  (cnt_zero_c)
    );

    reset_seq_down_counter #(
        .CNT_W  (CNT_W),
        .RST_VAL(0)
    ) u_gap_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (gap_load),
        .load_val(gap_val),
        .dec     (gap_dec),
        .zero_c  (gap_zero_c)
    );

    always_comb begin
        state_d   = state_q;
        dom_rst_d = dom_rst_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        gap_val   = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mask_d = req_mask;
                    if (req_mask == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        dom_rst_d = dom_rst_q | req_mask;
                        cnt_load  = 1'b1;
                        state_d   = ST_ASSERT;
                    end
                end
            end
            ST_ASSERT: begin
                if (cnt_zero_c) begin
                    state_d  = ST_RELEASE;
                    idx_d    = '0;
                    gap_load = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RELEASE: begin
                // Unmasked slots still burn their gap so timing is mask-independent.
                if (gap_zero_c) begin
                    if (mask_q[idx_q]) begin
                        dom_rst_d[idx_q] = 1'b0;
                    end
                    if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        gap_load = 1'b1;
                        gap_val  = CNT_W'(STAGE_GAP - 1);
                    end
                end else begin
                    gap_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ASSERT;
            dom_rst_q   <= '1;
            mask_q      <= '1;
            idx_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dom_rst_q   <= dom_rst_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign req_ready = req_ready_q;
    assign dom_rst   = dom_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes, monitors match them.
module tb_reset_sequencer;

    typedef struct packed {
        logic [31:0] cyc;
        logic        chk;
        logic [6:0]  v;   // {req_ready, busy, done, dom_rst[3:0]}
    } exp_t;

    localparam logic [2:0] S_BUSY = 3'b010;
    localparam logic [2:0] S_DONE = 3'b011;
    localparam logic [2:0] S_IDLE = 3'b100;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    logic       rst0 = 1'b1, rst1 = 1'b1;
    logic       req_valid0 = 1'b0, req_valid1 = 1'b0;
    logic [3:0] req_mask0 = 4'b0000;
    logic [1:0] req_mask1 = 2'b00;
    logic       req_ready0, busy0, done0, req_ready1, busy1, done1;
    logic [3:0] dom_rst0;
    logic [1:0] dom_rst1;

    exp_t q0[$];
    exp_t q1[$];

    reset_sequencer #(.NUM_DOMAINS(4), .ASSERT_CYCLES(16), .STAGE_GAP(4), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_mask(req_mask0), .dom_rst(dom_rst0), .busy(busy0), .done(done0)
    );

    reset_sequencer #(.NUM_DOMAINS(2), .ASSERT_CYCLES(1), .STAGE_GAP(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_mask(req_mask1), .dom_rst(dom_rst1), .busy(busy1), .done(done1)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic exp0(input int c, input logic chk, input logic [6:0] v);
        exp_t e;
        e.cyc = 32'(c);
        e.chk = chk;
        e.v   = v;
        q0.push_back(e);
    endtask

    task automatic exp1(input int c, input logic chk, input logic [6:0] v);
        exp_t e;
        e.cyc = 32'(c);
        e.chk = chk;
        e.v   = v;
        q1.push_back(e);
    endtask

    // Full-mask sequence on the 4-domain instance, E0 = e.
    task automatic power_on0(input int e);
        exp0(e + 17, 1'b1, {S_BUSY, 4'b1110});
        exp0(e + 21, 1'b1, {S_BUSY, 4'b1100});
        exp0(e + 25, 1'b1, {S_BUSY, 4'b1000});
        exp0(e + 29, 1'b1, {S_DONE, 4'b0000});
        exp0(e + 30, 1'b1, {S_IDLE, 4'b0000});
    endtask

    task automatic compare(input string nm, input exp_t e, input logic [6:0] got);
        n_tests++;
        if (got !== e.v || (e.chk && (32'(cyc) != e.cyc))) begin
            n_fail++;
            $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d%s",
                     nm, got, cyc, e.v, e.cyc, e.chk ? "" : " (any)");
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor for the 4-domain instance.
    initial begin
        logic [6:0] obs, prev;
        exp_t e;
        prev = 'x;
        forever begin
            @(negedge clk);
            obs = {req_ready0, busy0, done0, dom_rst0};
            if (obs !== prev) begin
                if (q0.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dut0_unexpected: got %b at cycle %0d, expected no change", obs, cyc);
                end else begin
                    e = q0.pop_front();
                    compare("dut0_event", e, obs);
                end
                prev = obs;
            end
        end
    end

    // Monitor for the 2-domain corner instance.
    initial begin
        logic [6:0] obs, prev;
        exp_t e;
        prev = 'x;
        forever begin
            @(negedge clk);
            obs = {req_ready1, busy1, done1, 2'b00, dom_rst1};
            if (obs !== prev) begin
                if (q1.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dut1_unexpected: got %b at cycle %0d, expected no change", obs, cyc);
                end else begin
                    e = q1.pop_front();
                    compare("dut1_event", e, obs);
                end
                prev = obs;
            end
        end
    end

    initial begin
        int e0, e1;
        exp0(0, 1'b0, {S_BUSY, 4'b1111});
        exp1(0, 1'b0, {S_BUSY, 4'b0011});

        // Power-on on both instances; the next edge is the last one with rst high.
        @(negedge clk);
        e0 = cyc + 1;
        power_on0(e0);
        exp1(e0 + 2, 1'b1, {S_BUSY, 4'b0010});
        exp1(e0 + 3, 1'b1, {S_DONE, 4'b0000});
        exp1(e0 + 4, 1'b1, {S_IDLE, 4'b0000});
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        wait_cyc(e0 + 30);

        // Partial request, mask 0101.
        req_valid0 = 1'b1;
        req_mask0  = 4'b0101;
        e0 = cyc + 1;
        exp0(e0,      1'b1, {S_BUSY, 4'b0101});
        exp0(e0 + 17, 1'b1, {S_BUSY, 4'b0100});
        exp0(e0 + 25, 1'b1, {S_BUSY, 4'b0000});
        exp0(e0 + 29, 1'b1, {S_DONE, 4'b0000});
        exp0(e0 + 30, 1'b1, {S_IDLE, 4'b0000});
        @(negedge clk);
        req_valid0 = 1'b0;
        wait_cyc(e0 + 31);

        // Empty mask goes straight to DONE.
        req_valid0 = 1'b1;
        req_mask0  = 4'b0000;
        e0 = cyc + 1;
        exp0(e0,     1'b1, {S_DONE, 4'b0000});
        exp0(e0 + 1, 1'b1, {S_IDLE, 4'b0000});
        @(negedge clk);
        req_valid0 = 1'b0;
        wait_cyc(e0 + 3);

        // Request held across a power-on; accepted only on the first IDLE edge.
        rst0       = 1'b1;
        req_valid0 = 1'b1;
        req_mask0  = 4'b1000;
        e0 = cyc + 1;
        exp0(e0, 1'b1, {S_BUSY, 4'b1111});
        power_on0(e0);
        exp0(e0 + 31,      1'b1, {S_BUSY, 4'b1000});
        exp0(e0 + 31 + 29, 1'b1, {S_DONE, 4'b0000});
        exp0(e0 + 31 + 30, 1'b1, {S_IDLE, 4'b0000});
        @(negedge clk);
        rst0 = 1'b0;
        wait_cyc(e0 + 31);
        req_valid0 = 1'b0;
        wait_cyc(e0 + 31 + 32);

        // rst pulsed one cycle after dom_rst[1] releases restarts power-on.
        rst0 = 1'b1;
        e0 = cyc + 1;
        exp0(e0,      1'b1, {S_BUSY, 4'b1111});
        exp0(e0 + 17, 1'b1, {S_BUSY, 4'b1110});
        exp0(e0 + 21, 1'b1, {S_BUSY, 4'b1100});
        @(negedge clk);
        rst0 = 1'b0;
        wait_cyc(e0 + 22);
        rst0 = 1'b1;
        e1 = cyc + 1;
        exp0(e1, 1'b1, {S_BUSY, 4'b1111});
        power_on0(e1);
        @(negedge clk);
        rst0 = 1'b0;
        wait_cyc(e1 + 33);

        n_tests++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL dut0_pending: %0d events outstanding, expected 0", q0.size());
        end
        n_tests++;
        if (q1.size() != 0) begin
            n_fail++;
            $display("FAIL dut1_pending: %0d events outstanding, expected 0", q1.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
